// File: rtl/if_id_queue_pkg.sv
// Shared types and constants for the IF/ID decoupling queue.
package if_id_queue_pkg;
  localparam int          DEPTH_DEF = 4;
  localparam int          PC_W      = 32;
  localparam int          ENTRY_W   = 64;
  localparam logic [31:0] NOP       = 32'd0;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [31:0]     instr;
  } entry_t;
endpackage

// File: rtl/if_id_queue_if.sv
// Fetch/decode handshake bundle around the IF/ID queue.
interface if_id_queue_if #(parameter int AW = 2);
  import if_id_queue_pkg::*;

  logic            flush;
  logic            push_valid;
  logic [PC_W-1:0] push_pc;
  logic [31:0]     push_instr;
  logic            full;
  logic            pop;
  logic            out_valid;
  logic [PC_W-1:0] out_pc;
  logic [31:0]     out_instr;
  logic [AW:0]     count;

  modport master (output flush, push_valid, push_pc, push_instr, pop,
                  input  full, out_valid, out_pc, out_instr, count);
  modport slave  (input  flush, push_valid, push_pc, push_instr, pop,
                  output full, out_valid, out_pc, out_instr, count);
endinterface

// File: rtl/if_id_queue_ram.sv
// Queue storage: register array, synchronous write, asynchronous read.
module queue_ram
  import if_id_queue_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  entry_t        wdata,
  input  logic [AW-1:0] raddr,
  output entry_t        rdata
);
  // No reset: stale contents are masked by the occupancy count.
  entry_t mem [DEPTH];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  assign rdata = mem[raddr];
endmodule

// File: rtl/if_id_queue.sv
// IF/ID instruction queue: pointer/count control around queue_ram.
module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = 2
) (
  input  logic clk,
  input  logic rst,
  if_id_queue_if.slave q
);
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          push_ok, pop_ok;
  entry_t        wr_entry, rd_entry;

  // Flush outranks both sides; a full queue refuses the push even if popped.
  assign push_ok = q.push_valid & ~q.full & ~q.flush;
  assign pop_ok  = q.pop & q.out_valid & ~q.flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (q.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop_ok)      count <= count + 1'b1;
      else if (!push_ok && pop_ok) count <= count - 1'b1;
    end
  end

  assign wr_entry = '{pc: q.push_pc, instr: q.push_instr};

  queue_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (push_ok),
    .waddr (wr_ptr),
    .wdata (wr_entry),
    .raddr (rd_ptr),
    .rdata (rd_entry)
  );

  assign q.count     = count;
  assign q.full      = (count == (AW+1)'(DEPTH));
  assign q.out_valid = (count != '0);
  assign q.out_pc    = q.out_valid ? rd_entry.pc    : NOP;
  assign q.out_instr = q.out_valid ? rd_entry.instr : NOP;
endmodule

// File: tb/tb_if_id_queue.sv
// Directed + random bench for if_id_queue against a queue-based model.
module tb_if_id_queue;
  import if_id_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  entry_t model [$];

  if_id_queue_if #(.AW(AW)) qif ();

  if_id_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .q   (qif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int n;
    n = model.size();
    chk({tag, ".count"},     32'(qif.count),     32'(n));
    chk({tag, ".out_valid"}, 32'(qif.out_valid), 32'(n != 0));
    chk({tag, ".full"},      32'(qif.full),      32'(n == DEPTH));
    chk({tag, ".out_pc"},    qif.out_pc,    (n != 0) ? model[0].pc    : NOP);
    chk({tag, ".out_instr"}, qif.out_instr, (n != 0) ? model[0].instr : NOP);
  endtask

  // One clock: drive inputs, advance the model by the queue's rules, compare.
  task automatic step(input string tag, input logic pv, input logic [31:0] pc,
                      input logic [31:0] instr, input logic pp, input logic fl);
    bit do_push, do_pop;
    qif.push_valid = pv;
    qif.push_pc    = pc;
    qif.push_instr = instr;
    qif.pop        = pp;
    qif.flush      = fl;
    do_push = pv && !fl && (model.size() < DEPTH);
    do_pop  = pp && !fl && (model.size() > 0);
    @(posedge clk);
    #1;
    if (fl) model.delete();
    else begin
      if (do_pop)  void'(model.pop_front());
      if (do_push) model.push_back('{pc: pc, instr: instr});
    end
    qif.push_valid = 1'b0;
    qif.pop        = 1'b0;
    qif.flush      = 1'b0;
    check_all(tag);
  endtask

  initial begin
    qif.flush = 1'b0; qif.push_valid = 1'b0; qif.pop = 1'b0;
    qif.push_pc = '0; qif.push_instr = '0;

    // Reset state
    #2;
    check_all("reset");
    #10 rst = 1'b0;

    // Single push, one-cycle latency
    step("push1", 1'b1, 32'd4, 32'hE3A01001, 1'b0, 1'b0);
    chk("push1.pc_const",    qif.out_pc,    32'd4);
    chk("push1.instr_const", qif.out_instr, 32'hE3A01001);
    step("flush0", 1'b0, 0, 0, 1'b0, 1'b1);

    // Fill, overflow attempt, drain in order
    for (int i = 1; i <= 4; i++) step("fill", 1'b1, 32'(4*i), 32'h1000 + 32'(i), 1'b0, 1'b0);
    chk("full_const", 32'(qif.full), 32'd1);
    step("overflow", 1'b1, 32'd20, 32'hDEAD, 1'b0, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      chk("drain.pc_const", qif.out_pc, 32'(4*i));
      step("drain", 1'b0, 0, 0, 1'b1, 1'b0);
    end
    chk("empty.instr_const", qif.out_instr, 32'd0);
    step("underflow", 1'b0, 0, 0, 1'b1, 1'b0);

    // Push+pop while full takes only the pop
    for (int i = 0; i < 4; i++) step("fill2", 1'b1, 32'h200 + 32'(4*i), 32'(i), 1'b0, 1'b0);
    step("full_pushpop", 1'b1, 32'h300, 32'hBEEF, 1'b1, 1'b0);
    chk("full_pushpop.count_const", 32'(qif.count), 32'd3);

    // Steady state of two entries across pointer wrap
    step("flush1", 1'b0, 0, 0, 1'b0, 1'b1);
    step("ss_a", 1'b1, 32'h400, 32'hA0, 1'b0, 1'b0);
    step("ss_b", 1'b1, 32'h404, 32'hA1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++)
      step("steady", 1'b1, 32'h408 + 32'(4*i), 32'hB0 + 32'(i), 1'b1, 1'b0);

    // Flush with a same-cycle push
    step("pre_flush", 1'b1, 32'h500, 32'hC0, 1'b0, 1'b0);
    step("flush_push", 1'b1, 32'h600, 32'hFF, 1'b0, 1'b1);
    chk("flush_push.valid_const", 32'(qif.out_valid), 32'd0);
    step("post_flush", 1'b0, 0, 0, 1'b1, 1'b0);

    // Asynchronous reset mid-cycle with two entries
    step("r_a", 1'b1, 32'h700, 32'hD0, 1'b0, 1'b0);
    step("r_b", 1'b1, 32'h704, 32'hD1, 1'b0, 1'b0);
    #3 rst = 1'b1;
    #1 model.delete();
    check_all("async_rst");
    #2 rst = 1'b0;
    step("after_rst", 1'b1, 32'h100, 32'hE0, 1'b0, 1'b0);
    chk("after_rst.pc_const", qif.out_pc, 32'h100);
    step("after_rst_pop", 1'b0, 0, 0, 1'b1, 1'b0);

    // Random traffic
    for (int i = 0; i < 400; i++)
      step("rand", 1'($urandom_range(0, 1)), $urandom, $urandom,
           1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/if_id_queue.md
IF_ID_QUEUE -- requirements
Module: if_id_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning entry count; it SHALL be a power of two and at least 2.
REQ-002 The block SHALL have parameter AW, default 2, meaning pointer width; it SHALL equal log2(DEPTH).
REQ-003 The block SHALL have port clk, input, 1 bit: clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 The block SHALL have port flush, input, 1 bit: branch taken; discards all queued and incoming entries.
REQ-006 The block SHALL have port push_valid, input, 1 bit: the fetch stage offers an entry this cycle.
REQ-007 The block SHALL have port push_pc, input, 32 bits: PC+4 value of the fetched instruction.
REQ-008 The block SHALL have port push_instr, input, 32 bits: fetched instruction word.
REQ-009 The block SHALL have port full, output, 1 bit: no free entry; drives the fetch-stage freeze.
REQ-010 The block SHALL have port pop, input, 1 bit: the decode stage consumes the head entry this cycle.
REQ-011 The block SHALL have port out_valid, output, 1 bit: a head entry is present.
REQ-012 The block SHALL have port out_pc, output, 32 bits: PC of the head entry.
REQ-013 The block SHALL have port out_instr, output, 32 bits: instruction of the head entry.
REQ-014 The block SHALL have port count, output, AW+1 bits: number of occupied entries, range 0..DEPTH.

Function
REQ-015 The block SHALL accept a push when push_valid=1, full=0 and flush=0; it SHALL write the entry at wr_ptr and increment wr_ptr modulo DEPTH.
REQ-016 The block SHALL accept a pop when pop=1, out_valid=1 and flush=0; it SHALL increment rd_ptr modulo DEPTH.
REQ-017 The block SHALL ignore a push offered while full=1; no state changes and the entry is lost. The fetch stage is frozen by full and re-presents the entry.
REQ-018 The block SHALL ignore a pop while out_valid=0; no underflow occurs and count stays 0.
REQ-019 On the next edge, count SHALL be count + accepted push − accepted pop; a simultaneous accepted push and pop leaves count unchanged.
REQ-020 When full=1, a simultaneous push and pop SHALL accept the pop only; the push is rejected and count becomes DEPTH−1.
REQ-021 Write-to-read latency SHALL be one cycle with no bypass; a push into an empty queue gives out_valid=1 on the following cycle.
REQ-022 full SHALL equal (count==DEPTH) and out_valid SHALL equal (count!=0), both decoded combinationally from registered count.
REQ-023 out_pc and out_instr SHALL show the entry at rd_ptr when out_valid=1, and SHALL be 32'd0 (NOP) when out_valid=0.
REQ-024 flush=1 SHALL have priority over push and pop; on that edge wr_ptr, rd_ptr and count SHALL clear to 0 and any same-cycle push SHALL be discarded.
REQ-025 After a flush, out_valid SHALL be 0 and full SHALL be 0 from the cycle following the flush edge.
REQ-026 Pointers SHALL wrap from DEPTH−1 to 0; entry order SHALL be strictly FIFO across the wrap.

Reset
REQ-027 Asserting rst SHALL immediately clear wr_ptr, rd_ptr and count to 0, giving out_valid=0, full=0, out_pc=0 and out_instr=0.
REQ-028 Storage contents SHALL not require reset; outputs are masked by REQ-023.
REQ-029 Reset asserted mid-operation SHALL drop all entries; the first push after release SHALL appear at the head.

Structure
REQ-030 The shared package SHALL hold the DEPTH default, the entry width of 64 ({pc, instr}) and the NOP constant 32'd0.
REQ-031 Storage SHALL be one sub-module, queue_ram: DEPTH×64 register array with synchronous write and asynchronous read.
REQ-032 Pointer, count and control logic SHALL reside in if_id_queue itself.

Verification
REQ-033 Reset, then push pc=4/instr=0xE3A01001 → next cycle out_valid=1, out_pc=4, out_instr=0xE3A01001, count=1.
REQ-034 Push 4 entries (pc 4, 8, 12, 16) with no pop → full=1, count=4; a fifth push is ignored; pops return 4, 8, 12, 16 in order, then out_valid=0 and out_instr=0.
REQ-035 With the queue full, push and pop together → only the pop is taken, count=3, full=0.
REQ-036 Keep 2 entries resident and push+pop together for 10 cycles across the pointer wrap → count stays 2 and output order matches input order.
REQ-037 With 3 entries, assert flush together with push_valid=1 → next cycle count=0, out_valid=0; the flushed-cycle entry never appears.
REQ-038 Assert rst asynchronously between edges with count=2 → outputs go to zero immediately; after release a push of pc=0x100 is the first entry popped.
